// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and defaults for the 5-stage pipeline sequencing controller.
//   ctrl_state_t     : controller state (RUN, DRAIN, HALTED)
//   REG_AW_DEF       : default register-file address width
//   DRAIN_CYCLES_DEF : default cycles to retire EX/MEM/WB after HALT leaves ID
//   CNT_W_DEF        : default performance counter width
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    localparam int REG_AW_DEF       = 4;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int CNT_W_DEF        = 16;

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard compare between the instruction in EX and the
// instruction in ID.
// Ports:
//   ex_memtoreg, ex_rf_write, ex_write_reg : EX instruction is a load writing a reg
//   id_read_reg1, id_read_reg2, id_uses_reg2 : ID source operands
//   hazard : ID needs the load result before it is available
// -----------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              ex_memtoreg,
    input  logic              ex_rf_write,
    input  logic [REG_AW-1:0] ex_write_reg,
    input  logic [REG_AW-1:0] id_read_reg1,
    input  logic [REG_AW-1:0] id_read_reg2,
    input  logic              id_uses_reg2,
    output logic              hazard
);

    // reg2 only matters when the ID instruction actually reads it; otherwise an
    // immediate field aliasing the load destination would stall needlessly.
    assign hazard = ex_memtoreg & ex_rf_write &
                    ((ex_write_reg == id_read_reg1) |
                     (id_uses_reg2 & (ex_write_reg == id_read_reg2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencing controller for the 5-stage 16-bit pipeline. Produces the
// PC / pipeline-register enables and flushes, inserts load-use bubbles, squashes
// wrong-path instructions on taken branches, freezes on memory wait cycles and
// sequences the halt drain.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   id_*                : ID-stage operand / HALT information
//   ex_*                : EX-stage load/destination/branch information
//   imem_stall          : instruction fetch not ready
//   dmem_stall          : data access in MEM not ready (freezes whole pipe)
//   *_wen, *_flush      : combinational register controls (flush wins over wen)
//   halted              : registered, core has halted
//   stall_cycles        : cycles with PC held (PIPE_PERF_EN only, else 0)
//   flush_count         : taken branches squashed (PIPE_PERF_EN only, else 0)
// Build option: define PIPE_PERF_EN to build the saturating perf counters.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_read_reg1,
    input  logic [REG_AW-1:0] id_read_reg2,
    input  logic              id_uses_reg2,
    input  logic              id_halt,
    input  logic              ex_memtoreg,
    input  logic              ex_rf_write,
    input  logic [REG_AW-1:0] ex_write_reg,
    input  logic              ex_branch_taken,
    input  logic              imem_stall,
    input  logic              dmem_stall,
    output logic              pc_wen,
    output logic              ifid_wen,
    output logic              ifid_flush,
    output logic              idex_wen,
    output logic              idex_flush,
    output logic              exmem_wen,
    output logic              memwb_wen,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    ctrl_state_t    state;
    logic [DCW-1:0] drain_cnt;
    logic           hazard;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .ex_memtoreg  (ex_memtoreg),
        .ex_rf_write  (ex_rf_write),
        .ex_write_reg (ex_write_reg),
        .id_read_reg1 (id_read_reg1),
        .id_read_reg2 (id_read_reg2),
        .id_uses_reg2 (id_uses_reg2),
        .hazard       (hazard)
    );

    // Output decode. Everything defaults to 0, which is also the frozen
    // (dmem_stall), HALTED and reset pattern. A flushed register still gets
    // its wen set; the flush makes it load a bubble instead of the upstream
    // value.
    always_comb begin
        pc_wen     = 1'b0;
        ifid_wen   = 1'b0;
        ifid_flush = 1'b0;
        idex_wen   = 1'b0;
        idex_flush = 1'b0;
        exmem_wen  = 1'b0;
        memwb_wen  = 1'b0;
        if (!rst && !dmem_stall) begin
            case (state)
                RUN: begin
                    exmem_wen = 1'b1;
                    memwb_wen = 1'b1;
                    idex_wen  = 1'b1;
                    if (ex_branch_taken) begin
                        pc_wen     = 1'b1;
                        ifid_wen   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (hazard) begin
                        idex_flush = 1'b1;
                    end else if (id_halt || imem_stall) begin
                        ifid_wen   = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        pc_wen   = 1'b1;
                        ifid_wen = 1'b1;
                    end
                end
                DRAIN: begin
                    ifid_wen   = 1'b1;
                    ifid_flush = 1'b1;
                    idex_wen   = 1'b1;
                    idex_flush = 1'b1;
                    exmem_wen  = 1'b1;
                    memwb_wen  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Sequencing FSM. HALT only leaves ID when no higher-priority event
    // (freeze, taken branch, load-use bubble) is in effect that cycle. The
    // drain counter only moves on unfrozen cycles, so a dmem wait lengthens
    // the drain by exactly the wait length. halted mirrors the HALTED state
    // but is its own flop so it is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!dmem_stall && !ex_branch_taken && !hazard && id_halt) begin
                        state     <= DRAIN;
                        drain_cnt <= DCW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (!dmem_stall) begin
                        if (drain_cnt == '0) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             branch_fire;

    assign branch_fire = !rst && (state == RUN) && !dmem_stall && ex_branch_taken;

    // Saturating performance counters; they stick at all-ones rather than
    // wrapping so a long run never reports a misleadingly small value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_wen && (state != HALTED) && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (branch_fire && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
